reg_to_apb: RTL

- Bridge from the register interface to an APB4 completer.
- Sits directly downstream of the AXI-to-register converter. Consumes its reg_req stream (addr/write/wdata/wstrb/valid) and returns rdata/error/ready.
- Runs one APB transfer at a time through a SETUP/ACCESS state machine.
- Optional ACCESS-phase timeout stops a hung completer from stalling the register bus.

---
 rtl/reg_to_apb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reg_to_apb.sv
// Register-interface to APB4 completer bridge.
// One transfer at a time through IDLE/SETUP/ACCESS/RESP, with an optional ACCESS-phase timeout.
module reg_to_apb #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [2:0]  PPROT          = 3'b000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      reg_valid_i,
    input  logic                      reg_write_i,
    input  logic [ADDR_WIDTH-1:0]     reg_addr_i,
    input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   reg_wstrb_i,
    output logic                      reg_ready_o,
    output logic [DATA_WIDTH-1:0]     reg_rdata_o,
    output logic                      reg_error_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_WIDTH-1:0]     paddr_o,
    output logic [DATA_WIDTH-1:0]     pwdata_o,
    output logic [DATA_WIDTH/8-1:0]   pstrb_o,
    output logic [2:0]                pprot_o,
    input  logic                      pready_i,
    input  logic [DATA_WIDTH-1:0]     prdata_i,
    input  logic                      pslverr_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   timeout_s;

    logic                   psel_r, psel_nxt_s;
    logic                   penable_r, penable_nxt_s;
    logic                   ready_r, ready_nxt_s;
    logic                   error_r, error_nxt_s;
    logic [DATA_WIDTH-1:0]  rdata_r, rdata_nxt_s;
    logic                   pwrite_r, pwrite_nxt_s;
    logic [ADDR_WIDTH-1:0]  paddr_r, paddr_nxt_s;
    logic [DATA_WIDTH-1:0]  pwdata_r, pwdata_nxt_s;
    logic [STRB_W-1:0]      pstrb_r, pstrb_nxt_s;

    assign timeout_s = TO_EN && (cnt_r == TO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; pready wins over a coincident timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (reg_valid_i) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of every registered output, derived from the state about to be entered.
    always_comb begin
        psel_nxt_s    = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
        penable_nxt_s = (state_nxt_s == ST_ACCESS);
        ready_nxt_s   = (state_nxt_s == ST_RESP);
        rdata_nxt_s   = {DATA_WIDTH{1'b0}};
        error_nxt_s   = 1'b0;
        cnt_nxt_s     = {CNT_W{1'b0}};
        pwrite_nxt_s  = pwrite_r;
        paddr_nxt_s   = paddr_r;
        pwdata_nxt_s  = pwdata_r;
        pstrb_nxt_s   = pstrb_r;
        case (state_r)
            ST_IDLE: begin
                if (reg_valid_i) begin
                    pwrite_nxt_s = reg_write_i;
                    paddr_nxt_s  = reg_addr_i;
                    pwdata_nxt_s = reg_wdata_i;
                    pstrb_nxt_s  = reg_write_i ? reg_wstrb_i : {STRB_W{1'b0}};
                end else begin
                    pwrite_nxt_s = pwrite_r;
                    paddr_nxt_s  = paddr_r;
                    pwdata_nxt_s = pwdata_r;
                    pstrb_nxt_s  = pstrb_r;
                end
            end
            ST_ACCESS: begin
                cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
                if (pready_i) begin
                    rdata_nxt_s = pwrite_r ? {DATA_WIDTH{1'b0}} : prdata_i;
                    error_nxt_s = pslverr_i;
                end else if (timeout_s) begin
                    rdata_nxt_s = {DATA_WIDTH{1'b0}};
                    error_nxt_s = 1'b1;
                end else begin
                    rdata_nxt_s = {DATA_WIDTH{1'b0}};
                    error_nxt_s = 1'b0;
                end
            end
            default: begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output and capture registers; reset drops psel/penable without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            ready_r   <= 1'b0;
            error_r   <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_WIDTH{1'b0}};
            pwdata_r  <= {DATA_WIDTH{1'b0}};
            pstrb_r   <= {STRB_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
            ready_r   <= ready_nxt_s;
            error_r   <= error_nxt_s;
            rdata_r   <= rdata_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            pstrb_r   <= pstrb_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign psel_o      = psel_r;
    assign penable_o   = penable_r;
    assign reg_ready_o = ready_r;
    assign reg_error_o = error_r;
    assign reg_rdata_o = rdata_r;
    assign pwrite_o    = pwrite_r;
    assign paddr_o     = paddr_r;
    assign pwdata_o    = pwdata_r;
    assign pstrb_o     = pstrb_r;
    assign pprot_o     = PPROT;

endmodule
